fifo_n_sync: RTL and testbench

- Synchronous, parametrised successor to the N-relay micropipeline FIFO controller.
- Replaces the relay chain with RELAY_NUMS clocked elastic stages. Keeps the drive/free handshake naming and the per-stage fire strobes.
- Adds a data path, an occupancy count, an almost-full flag and a synchronous flush.
- Sits between a producer and a consumer that run on one clock. Fire strobes feed the downstream per-stage datapath enables.

---
 rtl/fifo_n_pkg.sv | 15 +
 rtl/fifo_relay_stage.sv | 36 +++
 rtl/fifo_n_sync.sv | 111 +++++++++++
 tb/tb_fifo_n_sync.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_n_pkg.sv
// rtl/fifo_n_pkg.sv - shared constants and helpers for the synchronous relay FIFO
package fifo_n_pkg;

    // Smallest depth for which the head/input stage split is meaningful
    localparam int MIN_DEPTH = 2;

    // Lowest legal almost-full threshold; the upper bound is the depth itself
    localparam int AFULL_MIN = 1;

    // Occupancy counter width able to represent 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_relay_stage.sv
// rtl/fifo_relay_stage.sv - one elastic stage: valid/data registers and capture strobe
module fifo_relay_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  load,
    input  logic                  take,
    input  logic [DATA_WIDTH-1:0] d,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  fire
);

    // Capture on load, empty on take; flush drops the token but keeps the data bits
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
            fire  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            fire  <= 1'b0;
        end else begin
            fire <= load;
            if (load) begin
                q     <= d;
                valid <= 1'b1;
            end else if (take) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_n_sync.sv
// rtl/fifo_n_sync.sv - clocked N-stage elastic FIFO with drive/free handshake
module fifo_n_sync
    import fifo_n_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int RELAY_NUMS  = 5,
    parameter int AFULL_LEVEL = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_drive,
    output logic                               o_free,
    input  logic [DATA_WIDTH-1:0]              i_data,
    output logic                               o_driveNext,
    input  logic                               i_freeNext,
    output logic [DATA_WIDTH-1:0]              o_data,
    output logic [RELAY_NUMS-1:0]              o_fire_n,
    output logic [cnt_width(RELAY_NUMS)-1:0]   o_count,
    output logic                               o_afull,
    output logic                               o_empty,
    input  logic                               i_flush
);

    localparam int                N        = RELAY_NUMS;
    localparam int                CNT_W    = cnt_width(RELAY_NUMS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  AFULL_AT = CNT_W'(AFULL_LEVEL);

    if (RELAY_NUMS < MIN_DEPTH) begin : g_bad_depth
        $error("fifo_n_sync: RELAY_NUMS must be at least %0d", MIN_DEPTH);
    end
    if (AFULL_LEVEL < AFULL_MIN || AFULL_LEVEL > RELAY_NUMS) begin : g_bad_afull
        $error("fifo_n_sync: AFULL_LEVEL must lie in %0d..RELAY_NUMS", AFULL_MIN);
    end

    logic [N-1:0]          valid;
    logic [N-1:0]          ready;
    logic [N-1:0]          take;
    logic [N-1:0]          load;
    logic [DATA_WIDTH-1:0] q [N];
    logic [CNT_W-1:0]      count;
    logic                  accept;
    logic                  deliver;

    // Ready ripples from the consumer back to the input stage so a full pipe can still move
    always_comb begin
        logic rdy;
        rdy   = i_freeNext;
        take  = '0;
        ready = '0;
        for (int k = N - 1; k >= 0; k--) begin
            take[k]  = valid[k] & rdy;
            ready[k] = ~valid[k] | take[k];
            rdy      = ready[k];
        end
    end

    // A stage loads from its upstream neighbour whenever it can make room this cycle
    always_comb begin
        load    = '0;
        load[0] = i_drive & ready[0] & ~i_flush;
        for (int k = 1; k < N; k++) begin
            load[k] = valid[k-1] & ready[k];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic [DATA_WIDTH-1:0] stage_d;
        if (k == 0) begin : g_head_in
            assign stage_d = i_data;
        end else begin : g_chain
            assign stage_d = q[k-1];
        end

        fifo_relay_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (i_flush),
            .load  (load[k]),
            .take  (take[k]),
            .d     (stage_d),
            .valid (valid[k]),
            .q     (q[k]),
            .fire  (o_fire_n[k])
        );
    end

    assign accept  = load[0];
    assign deliver = take[N-1];

    // Occupancy tracks accepted minus delivered tokens; flush empties everything at once
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            count <= '0;
        end else if (accept && !deliver) begin
            count <= count + CNT_ONE;
        end else if (!accept && deliver) begin
            count <= count - CNT_ONE;
        end
    end

    assign o_free      = ready[0] & ~i_flush & ~rst;
    assign o_driveNext = valid[N-1];
    assign o_data      = q[N-1];
    assign o_count     = count;
    assign o_afull     = (count >= AFULL_AT);
    assign o_empty     = (count == '0);

endmodule

// File: tb/tb_fifo_n_sync.sv
// tb/tb_fifo_n_sync.sv - directed and scoreboarded checks for fifo_n_sync
module tb_fifo_n_sync;

    logic       clk;
    logic       rst;
    logic       i_drive;
    logic       o_free;
    logic [7:0] i_data;
    logic       o_driveNext;
    logic       i_freeNext;
    logic [7:0] o_data;
    logic [4:0] o_fire_n;
    logic [2:0] o_count;
    logic       o_afull;
    logic       o_empty;
    logic       i_flush;

    int tests;
    int fails;

    fifo_n_sync #(
        .DATA_WIDTH  (8),
        .RELAY_NUMS  (5),
        .AFULL_LEVEL (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .o_free      (o_free),
        .i_data      (i_data),
        .o_driveNext (o_driveNext),
        .i_freeNext  (i_freeNext),
        .o_data      (o_data),
        .o_fire_n    (o_fire_n),
        .o_count     (o_count),
        .o_afull     (o_afull),
        .o_empty     (o_empty),
        .i_flush     (i_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sb [$];
    logic       acc;
    logic       del;
    int         mcnt;
    int         pushed;
    int         cyc;

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; i_drive = 1'b0; i_data = 8'h00; i_freeNext = 1'b0; i_flush = 1'b0;
        step();
        step();

        // reset state
        #1;
        check("rst_free",  o_free, 0);
        check("rst_count", o_count, 0);
        check("rst_empty", o_empty, 1);
        check("rst_afull", o_afull, 0);
        check("rst_dnext", o_driveNext, 0);
        check("rst_data",  o_data, 0);
        check("rst_fire",  o_fire_n, 0);

        // single token walks through all five stages
        rst = 1'b0; i_drive = 1'b1; i_data = 8'hA5; i_freeNext = 1'b1;
        #1;
        check("t1_free", o_free, 1);
        step();
        i_drive = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check("t1_fire",  o_fire_n, 32'd1 << (c - 1));
            check("t1_count", o_count, 1);
            check("t1_dnext", o_driveNext, (c == 5) ? 1 : 0);
            if (c == 5) check("t1_data", o_data, 8'hA5);
            step();
        end
        #1;
        check("t1_count_after", o_count, 0);
        check("t1_empty_after", o_empty, 1);
        check("t1_fire_after",  o_fire_n, 0);

        // fill against a stalled consumer
        i_freeNext = 1'b0; i_drive = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            i_data = 8'(i);
            #1;
            check("t2_free",  o_free, 1);
            check("t2_count", o_count, i - 1);
            check("t2_afull", o_afull, (i - 1 >= 4) ? 1 : 0);
            step();
        end
        i_data = 8'h06;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_full_free",  o_free, 0);
            check("t2_full_count", o_count, 5);
            check("t2_full_afull", o_afull, 1);
            check("t2_head_valid", o_driveNext, 1);
            check("t2_head_data",  o_data, 8'h01);
            step();
        end

        // full-rate push and pop from full
        i_freeNext = 1'b1;
        for (int j = 0; j < 10; j++) begin
            i_data = 8'(6 + j);
            #1;
            check("t3_free",  o_free, 1);
            check("t3_data",  o_data, 1 + j);
            check("t3_count", o_count, 5);
            step();
        end
        i_drive = 1'b0; i_freeNext = 1'b0;
        #1;
        check("t3_count_end", o_count, 5);

        // random traffic against a scoreboard, seeded with what is still inside
        for (int v = 11; v <= 15; v++) sb.push_back(8'(v));
        mcnt = 5; pushed = 0; cyc = 0;
        while (pushed < 1000 && cyc < 20000) begin
            i_drive    = 1'($urandom_range(0, 1));
            i_data     = 8'($urandom_range(0, 255));
            i_freeNext = ($urandom_range(0, 99) < 30);
            #1;
            check("rnd_count", o_count, mcnt);
            check("rnd_empty", o_empty, (mcnt == 0) ? 1 : 0);
            check("rnd_afull", o_afull, (mcnt >= 4) ? 1 : 0);
            if (mcnt == 5) check("rnd_full_free", o_free, i_freeNext);
            if (mcnt == 0) check("rnd_empty_dnext", o_driveNext, 0);
            acc = i_drive & o_free;
            del = o_driveNext & i_freeNext;
            if (del) begin
                check("rnd_underflow", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) check("rnd_data", o_data, sb.pop_front());
            end
            if (acc) begin
                sb.push_back(i_data);
                pushed++;
            end
            mcnt = mcnt + int'(acc) - int'(del);
            step();
            cyc++;
        end
        check("rnd_done", (pushed >= 1000) ? 1 : 0, 1);
        i_drive = 1'b0; i_freeNext = 1'b1;
        for (int d = 0; d < 60; d++) begin
            #1;
            if (o_driveNext) begin
                check("drain_underflow", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) check("drain_data", o_data, sb.pop_front());
            end
            step();
        end
        #1;
        check("drain_left", sb.size(), 0);
        check("drain_count", o_count, 0);

        // flush with three tokens inside
        i_freeNext = 1'b0; i_drive = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'(8'h21 + i);
            #1;
            step();
        end
        #1;
        check("fl_count_before", o_count, 3);
        i_flush = 1'b1; i_data = 8'h99;
        #1;
        check("fl_free", o_free, 0);
        step();
        i_flush = 1'b0; i_drive = 1'b0;
        #1;
        check("fl_count", o_count, 0);
        check("fl_empty", o_empty, 1);
        check("fl_dnext", o_driveNext, 0);
        check("fl_fire",  o_fire_n, 0);
        step();
        #1;
        check("fl_count2", o_count, 0);
        check("fl_dnext2", o_driveNext, 0);

        // reset mid-stream with four tokens inside
        i_drive = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_data = 8'(8'h41 + i);
            #1;
            step();
        end
        #1;
        check("mr_count_before", o_count, 4);
        check("mr_afull_before", o_afull, 1);
        rst = 1'b1; i_freeNext = 1'b1;
        #1;
        check("mr_free", o_free, 0);
        step();
        rst = 1'b0; i_drive = 1'b0; i_freeNext = 1'b0;
        #1;
        check("mr_count", o_count, 0);
        check("mr_empty", o_empty, 1);
        check("mr_afull", o_afull, 0);
        check("mr_dnext", o_driveNext, 0);
        check("mr_data",  o_data, 0);
        check("mr_fire",  o_fire_n, 0);
        i_drive = 1'b1; i_data = 8'h3C; i_freeNext = 1'b1;
        #1;
        check("mr_push_free", o_free, 1);
        step();
        i_drive = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check("mr_dnext_lat", o_driveNext, (c == 5) ? 1 : 0);
            if (c == 5) check("mr_data_out", o_data, 8'h3C);
            step();
        end
        #1;
        check("mr_count_end", o_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
